// File: rtl/riscv_pkg.sv
// Shared integer-core widths and write-back types.
package riscv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LQ,
        WB_LD_BYP
    } wb_src_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Load-return queue: DEPTH entries of {rd, data}, FIFO order, wrapping pointers.
module wb_load_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  wb_entry_t                i_push_data,
    input  logic                     i_pop,
    output wb_entry_t                o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    wb_entry_t        r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
        end
    end

    // Payload storage needs no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file write master: ALU-priority arbitration over buffered load returns,
// registered write port and per-register pending scoreboard.
module reg_writeback_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned LQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rd,
    output logic              iss_ready,
    input  logic [REG_AW-1:0] rs_a,
    input  logic [REG_AW-1:0] rs_b,
    output logic              hazard_a,
    output logic              hazard_b,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              ld_valid,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    output logic              ld_ready,
    output logic              W_en,
    output logic [REG_AW-1:0] Address_write,
    output logic [XLEN-1:0]   data_write,
    output logic [NREGS-1:0]  pending
);

    localparam int unsigned CNT_W = $clog2(LQ_DEPTH) + 1;

    logic              r_wen;
    logic [REG_AW-1:0] r_waddr;
    logic [XLEN-1:0]   r_wdata;
    logic [NREGS-1:0]  r_pending;

    logic              w_alu_sel;
    logic              w_ld_acc;
    logic              w_lq_push;
    logic              w_lq_pop;
    logic              w_lq_full;
    logic              w_lq_empty;
    logic [CNT_W-1:0]  w_lq_count;
    wb_entry_t         w_lq_head;
    wb_entry_t         w_ld_entry;
    wb_src_e           w_src;
    logic [REG_AW-1:0] w_wr_rd;
    logic [XLEN-1:0]   w_wr_data;
    logic [NREGS-1:0]  w_pend_set;
    logic [NREGS-1:0]  w_pend_clr;
    logic [NREGS-1:0]  w_pend_nxt;

    assign w_alu_sel       = alu_valid && (alu_rd != '0);
    assign w_ld_acc        = ld_valid && ld_ready && (ld_rd != '0);
    assign w_ld_entry.rd   = ld_rd;
    assign w_ld_entry.data = ld_data;

    wb_load_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_lq_push),
        .i_push_data (w_ld_entry),
        .i_pop       (w_lq_pop),
        .o_head      (w_lq_head),
        .o_full      (w_lq_full),
        .o_empty     (w_lq_empty),
        .o_count     (w_lq_count)
    );

    // Source select: ALU, then queue head, then same-cycle load bypass.
    always_comb begin
        w_src     = WB_NONE;
        w_wr_rd   = '0;
        w_wr_data = '0;
        if (w_alu_sel)        w_src = WB_ALU;
        else if (!w_lq_empty) w_src = WB_LQ;
        else if (w_ld_acc)    w_src = WB_LD_BYP;
        case (w_src)
            WB_ALU: begin
                w_wr_rd   = alu_rd;
                w_wr_data = alu_data;
            end
            WB_LQ: begin
                w_wr_rd   = w_lq_head.rd;
                w_wr_data = w_lq_head.data;
            end
            WB_LD_BYP: begin
                w_wr_rd   = ld_rd;
                w_wr_data = ld_data;
            end
            default: ;
        endcase
    end

    assign w_lq_pop  = (w_src == WB_LQ);
    assign w_lq_push = w_ld_acc && (w_src != WB_LD_BYP);

    // Set after clear so a same-edge issue to the register being written stays pending.
    assign w_pend_set = (iss_valid && iss_ready && (iss_rd != '0)) ? (NREGS'(1) << iss_rd) : '0;
    assign w_pend_clr = r_wen ? (NREGS'(1) << r_waddr) : '0;
    assign w_pend_nxt = ((r_pending & ~w_pend_clr) | w_pend_set) & ~NREGS'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wen     <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_pending <= '0;
        end else begin
            r_wen     <= (w_src != WB_NONE);
            r_waddr   <= w_wr_rd;
            r_wdata   <= w_wr_data;
            r_pending <= w_pend_nxt;
        end
    end

    assign iss_ready     = (iss_rd == '0) || !r_pending[iss_rd];
    assign hazard_a      = r_pending[rs_a];
    assign hazard_b      = r_pending[rs_b];
    assign ld_ready      = !w_lq_full;
    assign W_en          = r_wen;
    assign Address_write = r_waddr;
    assign data_write    = r_wdata;
    assign pending       = r_pending;

    a_lq_count_bound: assert property (@(posedge clk) disable iff (!rst)
        w_lq_count <= CNT_W'(LQ_DEPTH));

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Bench for reg_writeback_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_reg_writeback_ctrl;
    import riscv_pkg::*;

    localparam int unsigned LQ_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              iss_valid;
    logic [REG_AW-1:0] iss_rd;
    logic              iss_ready;
    logic [REG_AW-1:0] rs_a;
    logic [REG_AW-1:0] rs_b;
    logic              hazard_a;
    logic              hazard_b;
    logic              alu_valid;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              ld_valid;
    logic [REG_AW-1:0] ld_rd;
    logic [XLEN-1:0]   ld_data;
    logic              ld_ready;
    logic              W_en;
    logic [REG_AW-1:0] Address_write;
    logic [XLEN-1:0]   data_write;
    logic [NREGS-1:0]  pending;

    always #5 clk = ~clk;

    reg_writeback_ctrl #(.LQ_DEPTH(LQ_DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .iss_valid     (iss_valid),
        .iss_rd        (iss_rd),
        .iss_ready     (iss_ready),
        .rs_a          (rs_a),
        .rs_b          (rs_b),
        .hazard_a      (hazard_a),
        .hazard_b      (hazard_b),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .ld_valid      (ld_valid),
        .ld_rd         (ld_rd),
        .ld_data       (ld_data),
        .ld_ready      (ld_ready),
        .W_en          (W_en),
        .Address_write (Address_write),
        .data_write    (data_write),
        .pending       (pending)
    );

    // Model state: queued loads, pending set, and the write visible this cycle.
    wb_entry_t         m_q[$];
    logic [NREGS-1:0]  m_pend;
    logic              m_wen;
    logic [REG_AW-1:0] m_addr;
    logic [XLEN-1:0]   m_data;

    int checks = 0;
    int fails  = 0;
    bit chk_en = 0;
    bit rec_en = 0;
    logic [REG_AW-1:0] rec_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return m_q.size() < int'(LQ_DEPTH);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pend = '0;
        m_wen  = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic model_step();
        bit                ld_acc;
        bit                iss_ok;
        bit                nw;
        logic [REG_AW-1:0] nrd;
        logic [XLEN-1:0]   ndata;
        wb_entry_t         e;
        if (!rst) begin
            model_reset();
            return;
        end
        ld_acc = ld_valid && m_ready() && (ld_rd != 0);
        iss_ok = iss_valid && ((iss_rd == 0) || !m_pend[iss_rd]);
        nw = 0; nrd = '0; ndata = '0;
        if (alu_valid && alu_rd != 0) begin
            nw = 1; nrd = alu_rd; ndata = alu_data;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            nw = 1; nrd = e.rd; ndata = e.data;
        end else if (ld_acc) begin
            nw = 1; nrd = ld_rd; ndata = ld_data;
            ld_acc = 0;
        end
        if (ld_acc) begin
            e.rd = ld_rd; e.data = ld_data;
            m_q.push_back(e);
        end
        if (m_wen) m_pend[m_addr] = 1'b0;
        if (iss_ok && iss_rd != 0) m_pend[iss_rd] = 1'b1;
        m_wen = nw; m_addr = nrd; m_data = ndata;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        iss_valid = 0;
        alu_valid = 0;
        ld_valid  = 0;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("W_en", W_en, m_wen);
            if (m_wen) begin
                chk("Address_write", Address_write, m_addr);
                chk("data_write", data_write, m_data);
            end
            chk("pending", pending, m_pend);
            chk("ld_ready", ld_ready, m_ready());
            chk("iss_ready", iss_ready, (iss_rd == 0) || !m_pend[iss_rd]);
            chk("hazard_a", hazard_a, m_pend[rs_a]);
            chk("hazard_b", hazard_b, m_pend[rs_b]);
        end
        if (rec_en && W_en) rec_q.push_back(Address_write);
    end

    int unsigned next_ld;
    bit          acc;
    bit          ld_hold;
    int unsigned alu_pct;

    initial begin
        rst = 1; idle();
        iss_rd = 0; rs_a = 0; rs_b = 0;
        alu_rd = 0; alu_data = 0; ld_rd = 0; ld_data = 0;
        model_reset();
        #3 rst = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_W_en", W_en, 0);
        chk("rst_pending", pending, 0);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_addr", Address_write, 0);
        chk("rst_data", data_write, 0);
        rst = 1;
        chk_en = 1;

        // ALU write and pending set/clear around it
        iss_valid = 1; iss_rd = 5; tick();
        iss_valid = 0; iss_rd = 0; alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        @(negedge clk); chk("t2_pend5_set", pending[5], 1); tick();
        idle();
        @(negedge clk);
        chk("t2_wen", W_en, 1); chk("t2_addr", Address_write, 5);
        chk("t2_data", data_write, 32'hDEADBEEF); chk("t2_pend5_during", pending[5], 1);
        tick();
        @(negedge clk); chk("t2_wen_pulse", W_en, 0); chk("t2_pend5_clr", pending[5], 0); tick();

        // Hazards on rd 7
        iss_valid = 1; iss_rd = 7; tick();
        iss_valid = 0; rs_a = 7; rs_b = 3;
        @(negedge clk);
        chk("t5_iss_ready", iss_ready, 0); chk("t5_haz_a", hazard_a, 1); chk("t5_haz_b", hazard_b, 0);
        tick();
        alu_valid = 1; alu_rd = 7; alu_data = 32'h0000_0777; tick();
        idle();
        @(negedge clk);
        chk("t5_wen", W_en, 1); chk("t5_addr", Address_write, 7); chk("t5_haz_a_hold", hazard_a, 1);
        tick();
        @(negedge clk); chk("t5_haz_a_clr", hazard_a, 0); chk("t5_iss_ready_set", iss_ready, 1); tick();
        rs_a = 0; rs_b = 0; iss_rd = 0;

        // Bypass of a single load into an idle queue
        ld_valid = 1; ld_rd = 9; ld_data = 32'h1234;
        @(negedge clk); chk("t6_cnt_pre", dut.u_lq.o_count, 0); tick();
        idle();
        @(negedge clk);
        chk("t6_wen", W_en, 1); chk("t6_addr", Address_write, 9); chk("t6_data", data_write, 32'h1234);
        chk("t6_cnt", dut.u_lq.o_count, 0);
        tick();
        @(negedge clk); chk("t6_single", W_en, 0); tick();

        // x0 results are dropped from both sources
        alu_valid = 1; alu_rd = 15; alu_data = 32'h15; ld_valid = 1; ld_rd = 3; ld_data = 32'h33; tick();
        alu_rd = 16; alu_data = 32'h16; ld_rd = 4; ld_data = 32'h44; tick();
        alu_rd = 0; ld_rd = 0; iss_valid = 1; iss_rd = 0;
        @(negedge clk); chk("t4_cnt2", dut.u_lq.o_count, 2); tick();
        @(negedge clk);
        chk("t4_pop3_addr", Address_write, 3); chk("t4_cnt1", dut.u_lq.o_count, 1);
        tick();
        @(negedge clk); chk("t4_pop4_addr", Address_write, 4); chk("t4_cnt0", dut.u_lq.o_count, 0); tick();
        @(negedge clk);
        chk("t4_no_wen", W_en, 0); chk("t4_pend", pending, 0); chk("t4_cnt0b", dut.u_lq.o_count, 0);
        tick();
        idle(); iss_rd = 0;

        // ALU priority over queued loads, full queue holds the fifth load
        next_ld = 1; rec_q.delete(); rec_en = 1;
        for (int i = 0; i < 14; i++) begin
            alu_valid = (i < 6); alu_rd = REG_AW'(20 + i); alu_data = $urandom;
            ld_valid = (next_ld <= 5); ld_rd = REG_AW'(next_ld); ld_data = $urandom;
            acc = ld_valid && m_ready();
            if (i == 4) begin
                @(negedge clk); chk("t3_ld_ready_full", ld_ready, 0);
            end
            tick();
            if (acc) next_ld++;
        end
        idle(); repeat (2) tick();
        rec_en = 0;
        chk("t3_nwrites", rec_q.size(), 11);
        for (int i = 0; i < 11; i++) begin
            if (i < rec_q.size())
                chk($sformatf("t3_order%0d", i), rec_q[i], (i < 6) ? 20 + i : i - 5);
        end

        // Reset mid-stream with three loads queued and a pending bit set
        iss_valid = 1; iss_rd = 12; alu_valid = 1; alu_rd = 21; ld_valid = 1; ld_rd = 1; tick();
        iss_valid = 0; alu_rd = 22; ld_rd = 2; tick();
        alu_rd = 23; ld_rd = 3; tick();
        alu_rd = 24; ld_valid = 0;
        @(negedge clk);
        chk("t1_cnt3", dut.u_lq.o_count, 3); chk("t1_pend12", pending[12], 1);
        #1 rst = 0; model_reset();
        #1;
        chk("t1_wen", W_en, 0); chk("t1_pend", pending, 0); chk("t1_ld_ready", ld_ready, 1);
        chk("t1_addr", Address_write, 0); chk("t1_data", data_write, 0); chk("t1_cnt", dut.u_lq.o_count, 0);
        tick();
        rst = 1; idle(); tick();
        @(negedge clk); chk("t1_discard", W_en, 0); tick();

        // Randomized traffic
        ld_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            alu_pct = (i < 1500) ? 75 : 30;
            iss_valid = ($urandom % 4) == 0; iss_rd = REG_AW'($urandom % 10);
            rs_a = REG_AW'($urandom % 10); rs_b = REG_AW'($urandom % 10);
            alu_valid = ($urandom % 100) < alu_pct; alu_rd = REG_AW'($urandom % 10); alu_data = $urandom;
            if (!ld_hold) begin
                ld_valid = $urandom % 2; ld_rd = REG_AW'($urandom % 10); ld_data = $urandom;
            end
            if ((i % 700) == 350) begin
                rst = 0; model_reset();
            end else begin
                rst = 1;
            end
            ld_hold = ld_valid && !m_ready();
            tick();
        end
        rst = 1; idle(); repeat (4) tick();

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
